// File: rtl/dsp_ctrl_pkg.sv
// rtl/dsp_ctrl_pkg.sv - shared FSM state and DSP48A1 OPMODE encodings
package dsp_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // X mux in bits [1:0] (01 = M), Z mux in bits [3:2] (10 = P)
  localparam logic [7:0] OP_ZERO = 8'b0000_0000;  // P = 0
  localparam logic [7:0] OP_MUL  = 8'b0000_0001;  // P = M
  localparam logic [7:0] OP_MAC  = 8'b0000_1001;  // P = P + M
  localparam logic [7:0] OP_HOLD = 8'b0000_1000;  // P = P + 0

endpackage

// File: rtl/dsp_opmode_dly.sv
// rtl/dsp_opmode_dly.sv - fixed-depth OPMODE delay line aligning ops with the M stage
module dsp_opmode_dly import dsp_ctrl_pkg::*; #(
  parameter int DEPTH = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] op_i,
  output logic [7:0] op_o
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ rst_i;
      assign op_o = op_i;
    end else begin : g_chain
      logic [7:0] chain_q [DEPTH];

      // Shift the issued op down the chain; reset parks every stage on ZERO
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < DEPTH; i++) chain_q[i] <= OP_ZERO;
        end else begin
          chain_q[0] <= op_i;
          for (int i = 1; i < DEPTH; i++) chain_q[i] <= chain_q[i-1];
        end
      end

      assign op_o = chain_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dsp48a1_mac_seq.sv
// rtl/dsp48a1_mac_seq.sv - dot-product sequencer feeding an external DSP48A1 MAC
module dsp48a1_mac_seq import dsp_ctrl_pkg::*; #(
  parameter int LAT    = 3,
  parameter int OP_LAG = 1,
  parameter int LEN_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  input  logic [47:0]      dsp_p,
  output logic             busy,
  output logic             res_valid,
  output logic [47:0]      res_data
);

  // DRAIN waits until the last MAC has landed in P, then samples it
  localparam int DRAIN_LEN = LAT + OP_LAG;
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

  state_e             state_q, state_d;
  logic [LEN_W:0]     count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [7:0]         op_q, op_d;
  logic [47:0]        res_q, res_d;
  logic [17:0]        a_q, b_q;
  logic               res_valid_q;
  logic               xfer;

  // count is one bit wider than len so len = 2^LEN_W-1 never wraps
  assign in_ready = (state_q == RUN) && (count_q < {1'b0, len_q});
  assign xfer     = in_valid && in_ready;

  // Next-state, issued op and result capture decisions
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    drain_d = drain_q;
    res_d   = res_q;
    op_d    = OP_ZERO;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          count_d = '0;
          if (len == '0) begin
            state_d = DONE;
            res_d   = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          op_d    = (count_q == '0) ? OP_MUL : OP_MAC;
          count_d = count_q + 1'b1;
          if (count_d == {1'b0, len_q}) begin
            state_d = DRAIN;
            drain_d = '0;
          end
        end else begin
          // a bubble must not disturb P: clear before the first pair, hold after
          op_d = (count_q == '0) ? OP_ZERO : OP_HOLD;
        end
      end
      DRAIN: begin
        op_d = OP_HOLD;
        if (drain_q == DRAIN_W'(DRAIN_LEN - 1)) begin
          state_d = DONE;
          res_d   = dsp_p;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state, operand registers and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      count_q     <= '0;
      len_q       <= '0;
      drain_q     <= '0;
      res_q       <= '0;
      op_q        <= OP_ZERO;
      a_q         <= '0;
      b_q         <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      len_q       <= len_d;
      drain_q     <= drain_d;
      res_q       <= res_d;
      op_q        <= op_d;
      res_valid_q <= (state_q == DONE);
      if (xfer) begin
        a_q <= in_a;
        b_q <= in_b;
      end
    end
  end

  // op_q moves with the operands; the delay line lines it up with M
  dsp_opmode_dly #(
    .DEPTH (OP_LAG)
  ) u_opmode_dly (
    .clk_i (CLK),
    .rst_i (RST),
    .op_i  (op_q),
    .op_o  (dsp_opmode)
  );

  assign dsp_a     = a_q;
  assign dsp_b     = b_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_q;

endmodule

// File: tb/tb_dsp48a1_mac_seq.sv
// tb/tb_dsp48a1_mac_seq.sv - self-checking bench for dsp48a1_mac_seq with a DSP48A1 pipeline model
module tb_dsp48a1_mac_seq;

  localparam int LAT    = 3;
  localparam int OP_LAG = 1;
  localparam int LEN_W  = 8;
  localparam int RES_LAT = LAT + OP_LAG + 2;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [17:0]      in_a, in_b;
  logic [17:0]      dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic [47:0]      dsp_p;
  logic             busy, res_valid;
  logic [47:0]      res_data;

  always #5 CLK = ~CLK;

  dsp48a1_mac_seq #(.LAT(LAT), .OP_LAG(OP_LAG), .LEN_W(LEN_W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_p(dsp_p),
    .busy(busy), .res_valid(res_valid), .res_data(res_data)
  );

  // DSP48A1 stand-in: A1REG/B1REG, MREG, OPMODEREG, PREG, CE=1, RST=0
  logic signed [17:0] a1_q = '0, b1_q = '0;
  logic signed [35:0] m_q = '0;
  logic [7:0]         opr_q = '0;
  logic [47:0]        p_q = '0;
  always @(posedge CLK) begin
    a1_q  <= dsp_a;
    b1_q  <= dsp_b;
    m_q   <= a1_q * b1_q;
    opr_q <= dsp_opmode;
    p_q   <= ((opr_q[3:2] == 2'b10) ? p_q : 48'd0) +
             ((opr_q[1:0] == 2'b01) ? {{12{m_q[35]}}, m_q} : 48'd0);
  end
  assign dsp_p = p_q;

  int cyc = 0;
  int pulses = 0;
  int ready_cnt = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (res_valid) pulses <= pulses + 1;
    if (in_ready) ready_cnt <= ready_cnt + 1;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  logic signed [17:0] qa[$];
  logic signed [17:0] qb[$];

  // Reference: plain signed dot product, truncated to the 48-bit P width
  function automatic logic [47:0] model_dot();
    longint s = 0;
    for (int i = 0; i < qa.size(); i++) s += longint'(qa[i]) * longint'(qb[i]);
    return s[47:0];
  endfunction

  typedef struct packed {
    logic [7:0]       n;
    logic [1:0]       gap;   // 0 none, 1 fixed two-cycle gaps, 2 random gaps
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    logic [47:0]      exp;
  } vec_t;

  vec_t tbl[6];

  task automatic run_job(input string tag, input int n, input int gap_mode,
                         input bit restart, input logic [47:0] exp);
    int idx, gap, guard, p0, last_acc, rc;
    bit got;
    logic [47:0] rd;
    idx = 0; gap = 0; guard = 0; got = 0; last_acc = 0; rc = 0; rd = '0;
    p0 = pulses;
    @(negedge CLK);
    start = 1'b1; len = LEN_W'(n);
    @(negedge CLK);
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    while (idx < n && guard < 4000) begin
      if (gap > 0) begin
        in_valid = 1'b0; in_a = 18'($urandom); in_b = 18'($urandom); gap--;
      end else begin
        in_valid = 1'b1; in_a = qa[idx]; in_b = qb[idx];
      end
      if (restart) begin start = 1'($urandom_range(0, 1)); len = LEN_W'($urandom); end
      if (in_valid && in_ready) begin
        last_acc = cyc;
        idx++;
        gap = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
      end
      @(negedge CLK);
      guard++;
    end
    in_valid = 1'b0;
    chk({tag, "_accepted"}, idx, n);
    start = restart;
    guard = 0;
    while (!got && guard < 400) begin
      if (res_valid) begin
        got = 1; rc = cyc; rd = res_data;
      end else begin
        if (guard >= 2) start = 1'b0;
        @(negedge CLK);
        guard++;
      end
    end
    start = 1'b0;
    chk({tag, "_got"}, got, 1);
    chk({tag, "_res"}, rd, exp);
    chk({tag, "_lat"}, rc - last_acc, RES_LAT);
    repeat (3) @(negedge CLK);
    #1;
    chk({tag, "_pulses"}, pulses - p0, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int p0, r0, sc, guard;
    start = 0; len = '0; in_valid = 0; in_a = '0; in_b = '0;

    // asynchronous reset, checked before the first clock edge
    #1 RST = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_dsp_a", dsp_a, 0);
    chk("rst_dsp_b", dsp_b, 0);
    chk("rst_opmode", dsp_opmode, 0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;

    // in_valid outside RUN must not load operands
    r0 = ready_cnt;
    in_valid = 1'b1; in_a = 18'h155; in_b = 18'h0AA;
    repeat (3) @(negedge CLK);
    in_valid = 1'b0;
    #1;
    chk("idle_dsp_a", dsp_a, 0);
    chk("idle_dsp_b", dsp_b, 0);
    chk("idle_ready", ready_cnt - r0, 0);

    tbl[0] = '{n: 8'd4, gap: 2'd0, a: {18'd4, 18'd3, 18'd2, 18'd1},
               b: {18'd2, 18'd2, 18'd2, 18'd2}, exp: 48'd20};
    tbl[1] = '{n: 8'd1, gap: 2'd0, a: {18'd0, 18'd0, 18'd0, 18'h3FFFD},
               b: {18'd0, 18'd0, 18'd0, 18'd5}, exp: 48'hFFFF_FFFF_FFF1};
    tbl[2] = '{n: 8'd3, gap: 2'd1, a: {18'd0, 18'd2, 18'd1, 18'd7},
               b: {18'd0, 18'd3, 18'd1, 18'd7}, exp: 48'd56};
    tbl[3] = '{n: 8'd3, gap: 2'd0, a: {18'd0, 18'd2, 18'd1, 18'd7},
               b: {18'd0, 18'd3, 18'd1, 18'd7}, exp: 48'd56};
    tbl[4] = '{n: 8'd2, gap: 2'd0, a: {18'd0, 18'd0, 18'h20000, 18'h20000},
               b: {18'd0, 18'd0, 18'h20000, 18'h20000}, exp: 48'h8_0000_0000};
    tbl[5] = '{n: 8'd4, gap: 2'd2, a: {18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF},
               b: {18'd4, 18'd3, 18'd2, 18'd1}, exp: 48'hFFFF_FFFF_FFF6};

    for (int k = 0; k < 6; k++) begin
      qa.delete(); qb.delete();
      for (int i = 0; i < int'(tbl[k].n); i++) begin
        qa.push_back(tbl[k].a[i]);
        qb.push_back(tbl[k].b[i]);
      end
      run_job($sformatf("vec%0d", k), int'(tbl[k].n), int'(tbl[k].gap), 1'b0, tbl[k].exp);
    end

    // len = 0: immediate zero result, no operand handshake
    r0 = ready_cnt;
    p0 = pulses;
    @(negedge CLK);
    start = 1'b1; len = '0; sc = cyc;
    @(negedge CLK);
    start = 1'b0;
    guard = 0;
    while (!res_valid && guard < 20) begin @(negedge CLK); guard++; end
    chk("len0_seen", res_valid, 1);
    chk("len0_lat", cyc - sc, 2);
    chk("len0_res", res_data, 0);
    repeat (3) @(negedge CLK);
    #1;
    chk("len0_ready", ready_cnt - r0, 0);
    chk("len0_pulses", pulses - p0, 1);

    // start hammered during RUN and DRAIN must be ignored
    qa.delete(); qb.delete();
    for (int i = 0; i < 4; i++) begin qa.push_back(18'(i + 1)); qb.push_back(18'd2); end
    run_job("restart", 4, 0, 1'b1, 48'd20);

    // reset mid-RUN aborts without a result
    p0 = pulses;
    @(negedge CLK);
    start = 1'b1; len = 8'd8;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 18'd9; in_b = 18'd9;
      @(negedge CLK);
    end
    in_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_res_data", res_data, 0);
    chk("abort_dsp_a", dsp_a, 0);
    chk("abort_opmode", dsp_opmode, 0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    repeat (12) @(negedge CLK);
    #1;
    chk("abort_no_pulse", pulses - p0, 0);
    qa.delete(); qb.delete();
    qa.push_back(18'd5); qb.push_back(18'd5);
    qa.push_back(18'd5); qb.push_back(18'd5);
    run_job("post_abort", 2, 0, 1'b0, 48'd50);

    // randomized jobs against the reference dot product
    for (int j = 0; j < 12; j++) begin
      int n;
      n = int'($urandom_range(1, 10));
      qa.delete(); qb.delete();
      for (int i = 0; i < n; i++) begin
        qa.push_back(18'($urandom));
        qb.push_back(18'($urandom));
      end
      run_job($sformatf("rnd%0d", j), n, 2, (j % 3) == 0, model_dot());
    end

    // longest legal vector
    qa.delete(); qb.delete();
    for (int i = 0; i < 255; i++) begin
      qa.push_back(18'($urandom));
      qb.push_back(18'($urandom));
    end
    run_job("len_max", 255, 0, 1'b0, model_dot());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dsp48a1_mac_seq.md
DSP48A1_MAC_SEQ -- requirements
Module: dsp48a1_mac_seq

Interface
REQ-001 SHALL have parameter LAT, default 3, giving the clock edges from a dsp_a/dsp_b update to the matching P update (A1REG=1, MREG=1, PREG=1).
REQ-002 SHALL have parameter OP_LAG, default 1, giving the cycles by which dsp_opmode trails its operands so that it aligns with the M stage (OPMODEREG=1).
REQ-003 SHALL have parameter LEN_W, default 8, the width of the vector-length field.
REQ-004 Port CLK, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port RST, input, 1: reset, asynchronous and active-high.
REQ-006 Port start, input, 1: one-cycle request to begin a dot product; sampled only in IDLE.
REQ-007 Port len, input, LEN_W: number of operand pairs, captured with start.
REQ-008 Port in_valid, input, 1: an operand pair is present on in_a/in_b.
REQ-009 Port in_ready, output, 1: the block accepts a pair this cycle.
REQ-010 Port in_a, input, 18: signed operand.
REQ-011 Port in_b, input, 18: signed operand.
REQ-012 Port dsp_a, output, 18: drives DSP48A1 A.
REQ-013 Port dsp_b, output, 18: drives DSP48A1 B.
REQ-014 Port dsp_opmode, output, 8: drives DSP48A1 OPMODE.
REQ-015 Port dsp_p, input, 48: DSP48A1 P result.
REQ-016 Port busy, output, 1: high whenever the state is not IDLE.
REQ-017 Port res_valid, output, 1: one-cycle pulse marking a valid result.
REQ-018 Port res_data, output, 48: the signed dot product.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE -> RUN SHALL occur on start with len != 0; IDLE -> DONE SHALL occur on start with len == 0, with res_data = 0.
REQ-021 in_ready SHALL be 1 only in RUN while the accepted count is less than len; a transfer occurs when in_valid && in_ready.
REQ-022 Every transfer SHALL register in_a/in_b onto dsp_a/dsp_b; otherwise dsp_a/dsp_b SHALL hold their values.
REQ-023 The issued op SHALL be one of: first transfer MUL 8'b0000_0001 (P=M); later transfers MAC 8'b0000_1001 (P=P+M); bubble after the first transfer HOLD 8'b0000_1000 (P=P+0); bubble before the first transfer ZERO 8'b0000_0000.
REQ-024 The issued op SHALL reach dsp_opmode exactly OP_LAG cycles after its operands reach dsp_a/dsp_b, through a delay line.
REQ-025 RUN -> DRAIN SHALL occur on the edge that accepts the len-th pair.
REQ-026 DRAIN SHALL last LAT+OP_LAG cycles and issue HOLD throughout.
REQ-027 DRAIN -> DONE: res_data SHALL capture dsp_p on the exit edge.
REQ-028 DONE SHALL assert res_valid for exactly one cycle, then return to IDLE; there is no result backpressure.
REQ-029 res_data SHALL hold its value until the next capture.
REQ-030 start SHALL be ignored in RUN, DRAIN and DONE.
REQ-031 in_valid SHALL be ignored outside RUN.
REQ-032 Bubbles SHALL NOT change the result.
REQ-033 The accepted count SHALL be LEN_W+1 bits wide and SHALL NOT wrap; len = 2^LEN_W-1 SHALL be legal.

Reset
REQ-034 RST SHALL force IDLE, count 0, in_ready=0, busy=0, res_valid=0, res_data=0, dsp_a=0, dsp_b=0, dsp_opmode=0, and clear the delay line, immediately and regardless of CLK.
REQ-035 A reset during RUN or DRAIN SHALL abort the operation with no res_valid; the first start after RST deasserts SHALL operate normally.

Structure
REQ-036 Package dsp_ctrl_pkg SHALL hold the state enum and the OPMODE constants OP_ZERO, OP_MUL, OP_MAC, OP_HOLD.
REQ-037 The sub-module dsp_opmode_dly (an OP_LAG-deep 8-bit register chain with asynchronous reset to OP_ZERO) SHALL implement REQ-024.
REQ-038 The bench SHALL instantiate DSP48A1 with A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, B_INPUT="DIRECT", with all CE tied 1 and all RST tied 0.

Verification
REQ-039 len=4, pairs (1,2),(2,2),(3,2),(4,2) back-to-back -> one res_valid pulse, res_data=48'd20, LAT+OP_LAG+2 cycles after the last accept.
REQ-040 len=1, a=18'h3FFFD (-3), b=5 -> res_data=48'hFFFF_FFFF_FFF1.
REQ-041 len=3, pairs (7,7),(1,1),(2,3) with 2-cycle in_valid gaps -> res_data=48'd56, matching the no-gap run.
REQ-042 len=0 -> res_valid on the second cycle after start, res_data=0, in_ready never asserted.
REQ-043 RST pulsed mid-RUN of len=8 -> all outputs at reset values, no res_valid; then len=2, pairs (5,5),(5,5) -> res_data=48'd50.
REQ-044 start re-pulsed during RUN/DRAIN -> ignored: a single res_valid and a correct result.
